// File: rtl/pkt_send_scheduler_pkg.sv
// Shared types and defaults for the packet send scheduler.
package pkt_send_scheduler_pkg;

    localparam int ENC_DATA_BITS      = 16;
    localparam int DATA_PKT_BITS      = 40;
    localparam int ACK_TIMEOUT_CYCLES = 1024;
    localparam int SEND_MAX_RETRIES   = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        ACK_WAIT
    } sched_state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_send_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request starting one past the last grant.
module pkt_send_scheduler_rr_arbiter
    import pkt_send_scheduler_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Scan N candidates in rotating order, keep the first hit.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pkt_send_scheduler.sv
// Packet send scheduler: arbitration, transmit, ack wait, timeout and retry.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no packet in flight, waiting for link_up and a request
//   LOAD     | one cycle: send_start pulse, req_ack on the first attempt
//   SEND     | sender shifting the packet out, waiting for send_done
//   ACK_WAIT | waiting for the peer ack, timeout_cnt running
module pkt_send_scheduler
    import pkt_send_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = ACK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = SEND_MAX_RETRIES,
    localparam int IW = clog2_min1(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             link_up,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ENC_DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic                             send_start,
    output logic [ENC_DATA_BITS-1:0]         send_data,
    input  logic                             send_done,
    input  logic                             ack_in,
    output logic                             done_ok,
    output logic                             done_fail,
    output logic                             busy,
    output logic [IW-1:0]                    active_id
);

    localparam int TW = clog2_min1(TIMEOUT_CYCLES);
    localparam int RW = clog2_min1(MAX_RETRIES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    sched_state_t state, state_nxt;
    logic [TW-1:0] timeout_cnt;
    logic [RW-1:0] retry_cnt;
    logic [IW-1:0] last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic grant_any;
    logic [ENC_DATA_BITS-1:0] grant_data;
    logic accept, tmo_clr, tmo_en, rty_clr, rty_en, ok_nxt, fail_nxt;

    pkt_send_scheduler_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    // One-hot mux of the granted requester's payload.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_data = grant_data | req_data[i*ENC_DATA_BITS +: ENC_DATA_BITS];
        end
    end

    // Next state and counter controls; link drop beats ack, ack beats timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        rty_clr   = 1'b0;
        rty_en    = 1'b0;
        ok_nxt    = 1'b0;
        fail_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (link_up && grant_any) begin
                    accept    = 1'b1;
                    rty_clr   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!link_up) begin
                    fail_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (!link_up) begin
                    fail_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (send_done) begin
                    tmo_clr   = 1'b1;
                    state_nxt = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (!link_up) begin
                    fail_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (ack_in) begin
                    ok_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_cnt == TMO_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        fail_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        rty_en    = 1'b1;
                        state_nxt = LOAD;
                    end
                end else begin
                    tmo_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    // Timeout counter: cleared on entry to ACK_WAIT, exits before it could wrap.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)       timeout_cnt <= '0;
        else if (tmo_clr) timeout_cnt <= '0;
        else if (tmo_en)  timeout_cnt <= timeout_cnt + TW'(1);
    end

    // Retry counter: cleared on accept, bumped on each retransmission.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)       retry_cnt <= '0;
        else if (rty_clr) retry_cnt <= '0;
        else if (rty_en)  retry_cnt <= retry_cnt + RW'(1);
    end

    // Registered outputs and the accepted packet context.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            last_grant <= IW'(NUM_REQ - 1);
            send_data  <= '0;
            active_id  <= '0;
            done_ok    <= 1'b0;
            done_fail  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done_ok   <= ok_nxt;
            done_fail <= fail_nxt;
            busy      <= (state_nxt != IDLE);
            if (accept) begin
                send_data  <= grant_data;
                active_id  <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Strobes decoded from LOAD only; req_ack only on the first attempt.
    always_comb begin
        send_start = (state == LOAD);
        req_ack    = '0;
        if (state == LOAD && retry_cnt == '0) req_ack[active_id] = 1'b1;
    end

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// Randomized bench for pkt_send_scheduler against a packet-lifecycle model.
module tb_pkt_send_scheduler;
    import pkt_send_scheduler_pkg::*;

    localparam int NR = 2;
    localparam int TO = 8;
    localparam int MR = 2;
    localparam int P  = DATA_PKT_BITS;
    localparam int W  = ENC_DATA_BITS;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_SEND = 2;
    localparam int M_WAIT = 3;

    logic clk = 1'b0;
    logic rst_l, link_up, send_done, ack_in;
    logic [NR-1:0] req, req_ack;
    logic [NR*W-1:0] req_data;
    logic send_start, done_ok, done_fail, busy;
    logic [W-1:0] send_data;
    logic [0:0] active_id;

    always #5 clk = ~clk;

    pkt_send_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .link_up    (link_up),
        .req        (req),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .send_start (send_start),
        .send_data  (send_data),
        .send_done  (send_done),
        .ack_in     (ack_in),
        .done_ok    (done_ok),
        .done_fail  (done_fail),
        .busy       (busy),
        .active_id  (active_id)
    );

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    // packet lifecycle model (expected view after each edge)
    int m_phase, m_owner, m_last, m_tries, m_wait_edge;
    logic [W-1:0] m_payload;
    bit m_ok, m_fail;

    // environment
    bit pend[NR];
    logic [W-1:0] pdata[NR];
    int snd_cnt;
    logic sd, prev_ss;
    int req_pct, ack_mode, ack_off, ack_pct, ack_other_pct, link_drop_pm, link_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_owner = 0; m_last = NR - 1; m_tries = 0;
        m_wait_edge = 0; m_payload = '0; m_ok = 0; m_fail = 0;
        snd_cnt = 0; prev_ss = 1'b0;
    endtask

    // Advance the model across the coming edge using the inputs now driven.
    task automatic model_edge();
        bit found;
        int i;
        m_ok = 0; m_fail = 0; found = 0;
        if (m_phase == M_IDLE) begin
            if (link_up && (|req)) begin
                for (int k = 1; k <= NR; k++) begin
                    i = (m_last + k) % NR;
                    if (!found && req[i]) begin
                        found = 1; m_owner = i; m_last = i; m_tries = 0;
                        m_payload = req_data[i*W +: W];
                        m_phase = M_LOAD;
                    end
                end
            end
        end else if (!link_up) begin
            m_fail = 1; m_phase = M_IDLE;
        end else if (m_phase == M_LOAD) begin
            m_phase = M_SEND;
        end else if (m_phase == M_SEND) begin
            if (send_done) begin m_phase = M_WAIT; m_wait_edge = edge_n + 1; end
        end else begin
            if (ack_in) begin
                m_ok = 1; m_phase = M_IDLE;
            end else if (edge_n + 1 - m_wait_edge == TO) begin
                if (m_tries < MR) begin m_tries++; m_phase = M_LOAD; end
                else begin m_fail = 1; m_phase = M_IDLE; end
            end
        end
    endtask

    task automatic compare();
        check("send_start", 32'(send_start), 32'(m_phase == M_LOAD));
        check("req_ack", 32'(req_ack), (m_phase == M_LOAD && m_tries == 0) ? (32'd1 << m_owner) : 32'd0);
        check("done_ok", 32'(done_ok), 32'(m_ok));
        check("done_fail", 32'(done_fail), 32'(m_fail));
        check("busy", 32'(busy), 32'(m_phase != M_IDLE));
        check("active_id", 32'(active_id), 32'(m_owner));
        check("send_data", 32'(send_data), 32'(m_payload));
    endtask

    task automatic drive_inputs();
        // sender: clears on the edge after send_start, raises send_done P cycles later
        if (prev_ss) begin snd_cnt = P; sd = 1'b0; end
        else if (snd_cnt > 0) begin snd_cnt--; if (snd_cnt == 0) sd = 1'b1; end
        prev_ss = send_start;
        send_done = sd;
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) pend[i] = 0;
            else if (!pend[i] && $urandom_range(99) < req_pct) begin
                pend[i] = 1; pdata[i] = W'($urandom);
            end
            req[i] = pend[i];
            req_data[i*W +: W] = pdata[i];
        end
        if (link_hold > 0) begin link_up = 1'b0; link_hold--; end
        else if ($urandom_range(999) < link_drop_pm) begin link_up = 1'b0; link_hold = $urandom_range(3); end
        else link_up = 1'b1;
        ack_in = 1'b0;
        if (m_phase == M_WAIT) begin
            if (ack_mode == 1)      ack_in = ($urandom_range(99) < ack_pct);
            else if (ack_mode == 2) ack_in = ((edge_n - m_wait_edge) == ack_off);
        end else if ($urandom_range(99) < ack_other_pct) begin
            ack_in = 1'b1;
        end
    endtask

    task automatic step();
        drive_inputs();
        model_edge();
        @(posedge clk);
        edge_n++;
        #1;
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until_phase(input int ph, input string tag);
        int guard;
        guard = 0;
        while (m_phase != ph && guard < 600) begin step(); guard++; end
        check(tag, 32'(guard < 600), 32'd1);
    endtask

    initial begin
        rst_l = 1'b1; link_up = 1'b0; req = '0; req_data = '0;
        send_done = 1'b1; ack_in = 1'b0; sd = 1'b1;
        for (int i = 0; i < NR; i++) begin pend[i] = 0; pdata[i] = '0; end
        req_pct = 0; ack_mode = 0; ack_off = 0; ack_pct = 0;
        ack_other_pct = 0; link_drop_pm = 0; link_hold = 0;
        model_reset();
        #1 rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst_l = 1'b1;

        // single request, ack 5 cycles into the wait
        pend[0] = 1; pdata[0] = 16'hA5A5; ack_mode = 2; ack_off = 5;
        run(80);

        // both held: rotating grants, each acked
        req_pct = 100; ack_off = 3;
        run(300);

        // never acked: full retry sequence then failure
        req_pct = 0; ack_mode = 0;
        run(200);
        pend[1] = 1; pdata[1] = 16'h3C3C;
        run(3 * (P + 2 + TO) + 20);

        // ack on the last timeout cycle; stray acks outside the wait
        pend[0] = 1; pdata[0] = 16'h1234; ack_mode = 2; ack_off = TO - 1; ack_other_pct = 100;
        run(150);
        ack_other_pct = 0;

        // link drop mid-send with requests held
        req_pct = 100; ack_off = 2;
        run_until_phase(M_SEND, "reach_send");
        run(5);
        link_hold = 6;
        run(120);

        // random traffic
        req_pct = 30; ack_mode = 1; ack_pct = 20; ack_other_pct = 10; link_drop_pm = 20;
        run(6000);

        // async reset mid ack-wait
        link_drop_pm = 0; link_hold = 0; ack_mode = 0; ack_other_pct = 0; req_pct = 100;
        run_until_phase(M_WAIT, "reach_wait");
        #2 rst_l = 1'b0;
        #1;
        model_reset();
        compare();
        pend[0] = 1; pend[1] = 1;
        @(negedge clk);
        rst_l = 1'b1;
        step();
        check("first_grant_after_reset", 32'(active_id), 32'd0);
        check("first_ack_after_reset", 32'(req_ack), 32'd1);
        ack_mode = 2; ack_off = 1;
        run(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pkt_send_scheduler.md
# pkt_send_scheduler

Arbitrates between packet requesters and sequences the single serial data sender: transmission, acknowledgement wait, timeout and retry. It sits between game-logic packet producers (for example garbage/attack and board-state packets) and the serial sender. It has exactly one packet in flight at a time and reports success or failure per packet.

## Interface
- NUM_REQ, 2, number of requesters; index 0 is first in round-robin order after reset
- TIMEOUT_CYCLES, 1024, cycles spent in ACK_WAIT before a retry; must be ≥ 2
- MAX_RETRIES, 3, retransmissions after the first attempt before declaring failure
- clk  in  1  GPIO clock
- rst_l  in  1  reset, asynchronous, active-low
- link_up  in  1  physical link established; low blocks acceptance and aborts an in-flight packet
- req  in  NUM_REQ  per-requester request level; held with req_data until the matching req_ack
- req_data  in  NUM_REQ×ENC_DATA_BITS  packed per-requester encoded payload
- req_ack  out  NUM_REQ  one-hot, 1-cycle accept pulse
- send_start  out  1  1-cycle pulse to the sender; send_data is valid in the same cycle
- send_data  out  ENC_DATA_BITS  latched payload of the active packet
- send_done  in  1  sender finished shifting; level signal, cleared by send_start
- ack_in  in  1  1-cycle pulse from the receiver: peer acknowledged the last packet
- done_ok  out  1  1-cycle pulse: active packet acknowledged
- done_fail  out  1  1-cycle pulse: retries exhausted, or link dropped
- busy  out  1  high in every state except IDLE
- active_id  out  $clog2(NUM_REQ) (minimum 1)  index of the requester owning the active packet

## Operation
- States: IDLE, LOAD, SEND, ACK_WAIT.
- IDLE: requires link_up=1 and any req bit set.
  - The arbiter picks the first set req, starting at last_grant+1 and wrapping.
  - On that edge: latch req_data[i] into send_data, set active_id=i, set last_grant=i, clear retry_cnt. Next state is LOAD.
- LOAD (exactly one cycle):
  - send_start=1.
  - req_ack[active_id]=1, only on the first attempt (retry_cnt=0).
  - Next state is SEND.
- SEND: wait for send_done=1, then go to ACK_WAIT and clear timeout_cnt. ack_in is ignored in SEND.
- ACK_WAIT: timeout_cnt increments every cycle. Exit conditions:
  - ack_in=1: done_ok pulse, go to IDLE.
  - timeout_cnt=TIMEOUT_CYCLES-1 with no ack_in, and retry_cnt<MAX_RETRIES: retry_cnt+1, go to LOAD. send_data is unchanged.
  - Same timeout with retry_cnt=MAX_RETRIES: done_fail pulse, go to IDLE.
- Width rules:
  - timeout_cnt width is $clog2(TIMEOUT_CYCLES).
  - retry_cnt width is $clog2(MAX_RETRIES+1).
  - Neither counter wraps; both saturate through the state exits above.
- Boundary conditions:
  - ack_in and timeout in the same cycle: ack wins, done_ok.
  - ack_in in IDLE, LOAD or SEND: ignored.
  - link_up falls in LOAD, SEND or ACK_WAIT: done_fail pulse next edge, go to IDLE. Priority order is link drop > ack > timeout.
  - req deasserted before its req_ack: no effect once accepted (payload already latched).
  - All req bits set continuously: grants rotate 0,1,…,NUM_REQ-1,0.
  - A requester may re-request in the cycle after its req_ack. It is then a normal candidate in IDLE.
- Reset (any state, including mid-packet):
  - State IDLE; last_grant = NUM_REQ-1, so req 0 wins first.
  - All outputs 0: send_start, send_data, req_ack, done_ok, done_fail, busy, active_id.

## Timing
- Request latency: req sampled high in IDLE at cycle T, with link_up=1 → LOAD at T+1, with send_start and req_ack at T+1.
- Sender handshake: the sender clears send_done the edge after send_start, so SEND sees send_done=0 at T+2. There is no false completion.
- Packet time: with DATA_PKT_BITS=P, send_done rises at T+1+P+1. The block enters ACK_WAIT the following edge.
- Minimum gap between packets: IDLE costs one cycle. Back-to-back send_start pulses are never closer than P+3 cycles.
- Timeout: ACK_WAIT spans exactly TIMEOUT_CYCLES cycles before LOAD or IDLE.
- Worst-case duration per packet: (MAX_RETRIES+1)·(P+2+TIMEOUT_CYCLES)+1 cycles.
- Output registration:
  - All outputs except req_ack and send_start are registered.
  - send_start and req_ack decode from state LOAD only, so they are glitch-free single-cycle pulses.

## Structure
- NetworkPkg:
  - Reuse ENC_DATA_BITS and DATA_PKT_BITS.
  - Add typedef enum logic [1:0] sched_state_t {IDLE, LOAD, SEND, ACK_WAIT}.
  - Add ACK_TIMEOUT_CYCLES and SEND_MAX_RETRIES as defaults for the two timing parameters.
- One sub-module, rr_arbiter #(N):
  - Inputs: req, last_grant.
  - Outputs: one-hot grant, grant_idx, any.
  - Purely combinational; last_grant is registered in the scheduler.
- Reuse the existing counter module for timeout_cnt and retry_cnt (load on clear, en on count).

## Test plan
- Reset, idle: NUM_REQ=2; req=2'b01, req_data[0]=A → send_start and req_ack=2'b01 at T+1, send_data=A. Emulate the sender with P=40. ack_in 5 cycles after send_done → done_ok pulse, busy=0 next cycle.
- Round-robin: req=2'b11 held; ack every packet → grant order 0,1,0,1. Each req_ack is one-hot and coincides with its send_start.
- Retry: TIMEOUT_CYCLES=8, MAX_RETRIES=2, never ack → 3 send_start pulses, each 8 cycles after the prior send_done. req_ack on the first only; done_fail after the third timeout.
- Ack at the boundary: ack_in on the last timeout cycle → done_ok, no extra send_start. ack_in during SEND → ignored, block still waits the timeout.
- Link drop: link_up→0 mid-SEND → done_fail next edge, IDLE. A req held while link_up=0 gets no req_ack; it is granted within 2 cycles after link_up returns.
- Async reset: assert rst_l=0 in ACK_WAIT → all outputs 0 immediately. After release, req=2'b11 → req 0 is granted first.
